// File: rtl/xi_index_emitter.sv
// xi_index_emitter
//   Serialises each accepted selected-element mask into element indices, lowest
//   set bit first, over a valid/ready stream. Each index is tagged with its
//   running output rank within the current sort pass, and the final index of
//   the pass is flagged. A one-cycle pulse marks pass completion, and a sticky
//   flag records a pass that emitted more than N indices.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_xi_valid/o_xi_ready/i_xi/i_xi_last   mask input stream
//   o_idx_valid/i_idx_ready/o_idx          index output stream
//   o_rank              output position of o_idx within the pass (saturates N-1)
//   o_idx_last          o_idx is the final index of the pass
//   o_pass_done         one-cycle pulse after the pass completes
//   o_overflow          sticky: more than N indices emitted in one pass

module xi_index_emitter #(
    parameter int unsigned N  = 8,
    parameter int unsigned IW = $clog2(N),
    parameter int unsigned CW = $clog2(N + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_xi_valid,
    output logic          o_xi_ready,
    input  logic [N-1:0]  i_xi,
    input  logic          i_xi_last,
    output logic          o_idx_valid,
    input  logic          i_idx_ready,
    output logic [IW-1:0] o_idx,
    output logic [IW-1:0] o_rank,
    output logic          o_idx_last,
    output logic          o_pass_done,
    output logic          o_overflow
);

    localparam logic [CW-1:0] NCnt    = CW'(N);
    localparam logic [IW-1:0] RankMax = IW'(N - 1);

    typedef enum logic [0:0] {
        StIdle,
        StDrain
    } state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  residual_q, residual_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pass_done_q, pass_done_d;
    logic          overflow_q, overflow_d;

    logic [IW-1:0] lowest_idx;
    logic [N-1:0]  residual_cleared;
    logic          residual_single;

    // Priority encoder: bit 0 has the highest priority, so scan downwards and
    // let the lowest set bit win.
    always_comb begin
        lowest_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (residual_q[i]) begin
                lowest_idx = IW'(i);
            end
        end
    end

    // x & (x-1) drops exactly the lowest set bit, i.e. the index being emitted.
    assign residual_cleared = residual_q & (residual_q - {{(N - 1){1'b0}}, 1'b1});
    assign residual_single  = (residual_q != '0) && (residual_cleared == '0);

    always_comb begin
        state_d     = state_q;
        residual_d  = residual_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        pass_done_d = 1'b0;
        overflow_d  = overflow_q;

        unique case (state_q)
            StIdle: begin
                if (i_xi_valid) begin
                    if (i_xi != '0) begin
                        residual_d = i_xi;
                        last_d     = i_xi_last;
                        state_d    = StDrain;
                    end else if (i_xi_last) begin
                        // Empty final mask still closes the pass.
                        pass_done_d = 1'b1;
                        cnt_d       = '0;
                    end
                end
            end
            StDrain: begin
                if (i_idx_ready) begin
                    residual_d = residual_cleared;
                    if (cnt_q < NCnt) begin
                        cnt_d = cnt_q + CW'(1);
                    end else begin
                        overflow_d = 1'b1;
                    end
                    if (residual_cleared == '0) begin
                        state_d = StIdle;
                        if (last_q) begin
                            pass_done_d = 1'b1;
                            cnt_d       = '0;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= StIdle;
            residual_q  <= '0;
            last_q      <= 1'b0;
            cnt_q       <= '0;
            pass_done_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            residual_q  <= residual_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            pass_done_q <= pass_done_d;
            overflow_q  <= overflow_d;
        end
    end

    assign o_xi_ready  = (state_q == StIdle);
    assign o_idx_valid = (state_q == StDrain);
    assign o_idx       = lowest_idx;
    assign o_rank      = (cnt_q >= NCnt) ? RankMax : cnt_q[IW-1:0];
    assign o_idx_last  = last_q & residual_single;
    assign o_pass_done = pass_done_q;
    assign o_overflow  = overflow_q;

endmodule

// File: tb/tb_xi_index_emitter.sv
// Bench for xi_index_emitter: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a queue-based model.

module tb_xi_index_emitter;

    localparam int N  = 8;
    localparam int IW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          xi_valid = 1'b0;
    logic          xi_ready;
    logic [N-1:0]  xi = '0;
    logic          xi_last = 1'b0;
    logic          idx_valid;
    logic          idx_ready = 1'b0;
    logic [IW-1:0] idx;
    logic [IW-1:0] rank;
    logic          idx_last;
    logic          pass_done;
    logic          overflow;

    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;

    // Model state: indices still to emit for the current mask, in order.
    int pend[$];
    bit m_last = 1'b0;
    int m_emitted = 0;
    bit m_ovf = 1'b0;
    bit m_pdone = 1'b0;

    always #5 clk = ~clk;

    xi_index_emitter #(.N(N)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_xi_valid (xi_valid),
        .o_xi_ready (xi_ready),
        .i_xi       (xi),
        .i_xi_last  (xi_last),
        .o_idx_valid(idx_valid),
        .i_idx_ready(idx_ready),
        .o_idx      (idx),
        .o_rank     (rank),
        .o_idx_last (idx_last),
        .o_pass_done(pass_done),
        .o_overflow (overflow)
    );

    task automatic expect_eq(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model, advanced on the same edge the DUT samples its inputs.
    always @(posedge clk) begin
        bit pd;
        pd = 1'b0;
        if (rst) begin
            pend.delete();
            m_last    = 1'b0;
            m_emitted = 0;
            m_ovf     = 1'b0;
        end else if (pend.size() == 0) begin
            if (xi_valid) begin
                if (xi != '0) begin
                    for (int b = 0; b < N; b++) if (xi[b]) pend.push_back(b);
                    m_last = xi_last;
                end else if (xi_last) begin
                    pd = 1'b1;
                    m_emitted = 0;
                end
            end
        end else if (idx_ready) begin
            void'(pend.pop_front());
            if (m_emitted >= N) m_ovf = 1'b1;
            else m_emitted++;
            if (pend.size() == 0 && m_last) begin
                pd = 1'b1;
                m_emitted = 0;
            end
        end
        m_pdone = pd;
    end

    // Compare process: outputs checked on the falling edge, away from updates.
    always @(negedge clk) begin
        if (check_en) begin
            expect_eq("xi_ready", int'(xi_ready), int'(pend.size() == 0));
            expect_eq("idx_valid", int'(idx_valid), int'(pend.size() != 0));
            expect_eq("pass_done", int'(pass_done), int'(m_pdone));
            expect_eq("overflow", int'(overflow), int'(m_ovf));
            if (pend.size() != 0) begin
                expect_eq("idx", int'(idx), pend[0]);
                expect_eq("rank", int'(rank), (m_emitted >= N) ? N - 1 : m_emitted);
                expect_eq("idx_last", int'(idx_last), int'(m_last && pend.size() == 1));
            end
        end
    end

    // Apply inputs for one clock edge, then settle just after it.
    task automatic step(input bit r, input bit v, input logic [N-1:0] m, input bit l,
                        input bit rdy);
        rst       = r;
        xi_valid  = v;
        xi        = m;
        xi_last   = l;
        idx_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    // Literal expectation of an emitted index.
    task automatic lit_idx(input string name, input int e_idx, input int e_rank,
                           input int e_last);
        expect_eq({name, ".valid"}, int'(idx_valid), 1);
        expect_eq({name, ".idx"}, int'(idx), e_idx);
        expect_eq({name, ".rank"}, int'(rank), e_rank);
        expect_eq({name, ".last"}, int'(idx_last), e_last);
    endtask

    initial begin
        // Reset state.
        step(1, 0, 8'h00, 0, 0);
        check_en = 1'b1;
        expect_eq("rst.xi_ready", int'(xi_ready), 1);
        expect_eq("rst.idx_valid", int'(idx_valid), 0);
        expect_eq("rst.pass_done", int'(pass_done), 0);
        expect_eq("rst.overflow", int'(overflow), 0);

        // Single mask 1010_0100 -> 2,5,7.
        step(0, 1, 8'hA4, 1, 1);
        lit_idx("single0", 2, 0, 0);
        step(0, 0, 8'h00, 0, 1);
        lit_idx("single1", 5, 1, 0);
        step(0, 0, 8'h00, 0, 1);
        lit_idx("single2", 7, 2, 1);
        step(0, 0, 8'h00, 0, 1);
        expect_eq("single.pdone", int'(pass_done), 1);
        expect_eq("single.ready", int'(xi_ready), 1);
        step(0, 0, 8'h00, 0, 1);
        expect_eq("single.pdone_off", int'(pass_done), 0);

        // Multi-mask pass: 0x11 then 0x06.
        step(0, 1, 8'h11, 0, 1);
        lit_idx("multi0", 0, 0, 0);
        step(0, 0, 8'h00, 0, 1);
        lit_idx("multi1", 4, 1, 0);
        step(0, 0, 8'h00, 0, 1);
        expect_eq("multi.bubble", int'(idx_valid), 0);
        expect_eq("multi.no_pdone", int'(pass_done), 0);
        step(0, 1, 8'h06, 1, 1);
        lit_idx("multi2", 1, 2, 0);
        step(0, 0, 8'h00, 0, 1);
        lit_idx("multi3", 2, 3, 1);
        step(0, 0, 8'h00, 0, 1);
        expect_eq("multi.pdone", int'(pass_done), 1);

        // Backpressure on mask 0x81.
        step(0, 1, 8'h81, 1, 0);
        lit_idx("bp0", 0, 0, 0);
        step(0, 0, 8'h00, 0, 0);
        lit_idx("bp1", 0, 0, 0);
        step(0, 0, 8'h00, 0, 0);
        lit_idx("bp2", 0, 0, 0);
        step(0, 0, 8'h00, 0, 1);
        lit_idx("bp3", 7, 1, 1);
        step(0, 0, 8'h00, 0, 0);
        lit_idx("bp4", 7, 1, 1);
        step(0, 0, 8'h00, 0, 1);
        expect_eq("bp.pdone", int'(pass_done), 1);

        // Empty masks.
        step(0, 1, 8'h00, 0, 1);
        expect_eq("empty0.valid", int'(idx_valid), 0);
        expect_eq("empty0.pdone", int'(pass_done), 0);
        step(0, 1, 8'h00, 1, 1);
        expect_eq("empty1.pdone", int'(pass_done), 1);
        step(0, 1, 8'h02, 1, 1);
        expect_eq("empty2.pdone", int'(pass_done), 0);
        lit_idx("empty2", 1, 0, 1);
        step(0, 0, 8'h00, 0, 1);

        // Overflow: 0xFF then 0x01.
        step(0, 1, 8'hFF, 0, 1);
        for (int k = 0; k < 7; k++) step(0, 0, 8'h00, 0, 1);
        lit_idx("ovf7", 7, 7, 0);
        step(0, 0, 8'h00, 0, 1);
        step(0, 1, 8'h01, 1, 1);
        lit_idx("ovf8", 0, 7, 1);
        expect_eq("ovf.before", int'(overflow), 0);
        step(0, 0, 8'h00, 0, 1);
        expect_eq("ovf.set", int'(overflow), 1);
        expect_eq("ovf.pdone", int'(pass_done), 1);
        step(0, 0, 8'h00, 0, 1);
        expect_eq("ovf.sticky", int'(overflow), 1);

        // Reset mid-drain.
        step(1, 0, 8'h00, 0, 0);
        expect_eq("rst2.overflow", int'(overflow), 0);
        step(0, 1, 8'hF0, 0, 1);
        lit_idx("mid0", 4, 0, 0);
        step(1, 0, 8'h00, 0, 1);
        expect_eq("mid.valid", int'(idx_valid), 0);
        expect_eq("mid.ready", int'(xi_ready), 1);
        step(0, 1, 8'h01, 1, 1);
        lit_idx("mid1", 0, 0, 1);
        step(0, 0, 8'h00, 0, 1);

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            logic [N-1:0] m;
            int kind;
            kind = int'($urandom_range(0, 7));
            if (kind == 0) m = '0;
            else if (kind < 5) m = N'($urandom) & N'($urandom);
            else m = N'($urandom);
            step(($urandom_range(0, 99) == 0), $urandom_range(0, 1) == 1, m,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 9) < 7);
        end
        step(0, 0, 8'h00, 0, 1);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
